// File: rtl/led_share_ctrl.sv
// led_share_ctrl: shares the user LEDs between the Nios LED PIO and a local
// pattern sequencer. Raw pushbuttons are synchronised and debounced; clean
// levels go to the button PIO and press events drive the ownership FSM.
module led_share_ctrl #(
  parameter int LED_W           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_CYCLES     = 12500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       pb_n,
  input  logic [LED_W-1:0] cpu_led,
  input  logic             cpu_req,
  output logic [3:0]       pb_clean,
  output logic [LED_W-1:0] led_out,
  output logic             cpu_grant,
  output logic [1:0]       mode
);

  typedef enum logic [1:0] {
    ST_CPU   = 2'b00,
    ST_SCAN  = 2'b01,
    ST_COUNT = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] STEP_LAST = ST_W'(STEP_CYCLES - 1);

  logic [3:0]       pb_meta_r;
  logic [3:0]       pb_sync_r;
  logic [3:0]       pb_clean_r;
  logic [DB_W-1:0]  db_cnt_r [4];
  logic [3:0]       press_r;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [LED_W-1:0] pattern_r;
  logic             paused_r;
  logic [ST_W-1:0]  step_cnt_r;
  logic             run_s;
  logic [LED_W-1:0] led_r;
  logic             cpu_grant_r;

  // Two-flop synchroniser followed by a per-bit stability counter; a press
  // pulse is raised on the same edge that the clean level falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pb_meta_r  <= 4'hF;
      pb_sync_r  <= 4'hF;
      pb_clean_r <= 4'hF;
      press_r    <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= {DB_W{1'b0}};
      end
    end else begin
      pb_meta_r <= pb_n;
      pb_sync_r <= pb_meta_r;
      press_r   <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (pb_sync_r[i] == pb_clean_r[i]) begin
          db_cnt_r[i] <= {DB_W{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_cnt_r[i]   <= {DB_W{1'b0}};
          pb_clean_r[i] <= ~pb_clean_r[i];
          press_r[i]    <= pb_clean_r[i];
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

  // Next-state selection: CPU demand first, then force-CPU, then mode advance.
  always_comb begin
    state_nxt_s = state_r;
    if (cpu_req) begin
      state_nxt_s = ST_CPU;
    end else if (press_r[3]) begin
      state_nxt_s = ST_CPU;
    end else if (press_r[1]) begin
      case (state_r)
        ST_CPU:   state_nxt_s = ST_SCAN;
        ST_SCAN:  state_nxt_s = ST_COUNT;
        ST_COUNT: state_nxt_s = ST_HOLD;
        ST_HOLD:  state_nxt_s = ST_CPU;
        default:  state_nxt_s = ST_CPU;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Step counter only advances while a sequencer mode is running.
  always_comb begin
    run_s = 1'b0;
    if ((state_r == ST_SCAN || state_r == ST_COUNT) && !paused_r) begin
      run_s = 1'b1;
    end else begin
      run_s = 1'b0;
    end
  end

  // State register; grant is registered alongside it so it tracks mode exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_CPU;
      cpu_grant_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      cpu_grant_r <= (state_nxt_s == ST_CPU);
    end
  end

  // Pattern, pause flag and step counter; all reload on entry to a new state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_r  <= LED_W'(1);
      paused_r   <= 1'b0;
      step_cnt_r <= {ST_W{1'b0}};
    end else if (state_nxt_s != state_r) begin
      step_cnt_r <= {ST_W{1'b0}};
      paused_r   <= 1'b0;
      case (state_nxt_s)
        ST_SCAN:  pattern_r <= LED_W'(1);
        ST_COUNT: pattern_r <= {LED_W{1'b0}};
        default:  pattern_r <= pattern_r;
      endcase
    end else begin
      if (run_s) begin
        if (step_cnt_r == STEP_LAST) begin
          step_cnt_r <= {ST_W{1'b0}};
          case (state_r)
            ST_SCAN:  pattern_r <= {pattern_r[LED_W-2:0], pattern_r[LED_W-1]};
            ST_COUNT: pattern_r <= pattern_r + LED_W'(1);
            default:  pattern_r <= pattern_r;
          endcase
        end else begin
          step_cnt_r <= step_cnt_r + ST_W'(1);
        end
      end else begin
        step_cnt_r <= step_cnt_r;
      end
      if (press_r[2] && (state_r == ST_SCAN || state_r == ST_COUNT)) begin
        paused_r <= ~paused_r;
      end else begin
        paused_r <= paused_r;
      end
    end
  end

  // LED drive register: CPU value while the CPU owns the LEDs, else the pattern.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_r <= {LED_W{1'b0}};
    end else if (state_r == ST_CPU) begin
      led_r <= cpu_led;
    end else begin
      led_r <= pattern_r;
    end
  end

  assign pb_clean  = pb_clean_r;
  assign led_out   = led_r;
  assign cpu_grant = cpu_grant_r;
  assign mode      = state_r;

endmodule

// File: tb/tb_led_share_ctrl.sv
// Scoreboard bench for led_share_ctrl: a behavioural model pushes the expected
// outputs each clock, a monitor pops and compares them; directed scenarios add
// spot checks against fixed values.
module tb_led_share_ctrl;

  localparam int LED_W = 8;
  localparam int DEB   = 4;
  localparam int STEP  = 3;

  logic             clk;
  logic             reset_n;
  logic [3:0]       pb_n;
  logic [LED_W-1:0] cpu_led;
  logic             cpu_req;
  logic [3:0]       pb_clean;
  logic [LED_W-1:0] led_out;
  logic             cpu_grant;
  logic [1:0]       mode;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [7:0] led;
    logic [3:0] pb;
    logic [1:0] mode;
    logic       grant;
  } exp_t;

  exp_t sb_q[$];

  led_share_ctrl #(
    .LED_W(LED_W),
    .DEBOUNCE_CYCLES(DEB),
    .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pb_n(pb_n),
    .cpu_led(cpu_led),
    .cpu_req(cpu_req),
    .pb_clean(pb_clean),
    .led_out(led_out),
    .cpu_grant(cpu_grant),
    .mode(mode)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: modes are numbered 0..3, pattern is an integer, and a
  // level is accepted once the last DEB synchronised samples all disagree.
  int         m_mode, m_pat, m_step, m_nm;
  bit         m_paused;
  logic [3:0] m_clean, m_press, m_s1, m_s2;
  logic [DEB-1:0] m_win [4];
  exp_t       m_e;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_mode = 0; m_pat = 1; m_step = 0; m_paused = 0;
        m_clean = 4'hF; m_press = 4'h0; m_s1 = 4'hF; m_s2 = 4'hF;
        for (int i = 0; i < 4; i++) m_win[i] = {DEB{1'b1}};
        sb_q.delete();
        m_e = '{led: 8'h00, pb: 4'hF, mode: 2'b00, grant: 1'b1};
        sb_q.push_back(m_e);
      end else begin
        m_e.led = (m_mode == 0) ? cpu_led : 8'(m_pat);
        m_nm = m_mode;
        if (cpu_req) m_nm = 0;
        else if (m_press[3]) m_nm = 0;
        else if (m_press[1]) m_nm = (m_mode + 1) % 4;
        if (m_nm != m_mode) begin
          m_step = 0;
          m_paused = 0;
          if (m_nm == 1) m_pat = 1;
          else if (m_nm == 2) m_pat = 0;
        end else begin
          if ((m_mode == 1 || m_mode == 2) && !m_paused) begin
            m_step++;
            if (m_step == STEP) begin
              m_step = 0;
              if (m_mode == 1) m_pat = ((m_pat << 1) | (m_pat >> 7)) & 255;
              else m_pat = (m_pat + 1) % 256;
            end
          end
          if ((m_mode == 1 || m_mode == 2) && m_press[2]) m_paused = !m_paused;
        end
        m_mode = m_nm;
        for (int i = 0; i < 4; i++) begin
          m_press[i] = 1'b0;
          m_win[i] = {m_win[i][DEB-2:0], m_s2[i]};
          if (m_win[i] == {DEB{~m_clean[i]}}) begin
            m_press[i] = m_clean[i];
            m_clean[i] = ~m_clean[i];
          end
        end
        m_s2 = m_s1;
        m_s1 = pb_n;
        m_e.pb = m_clean;
        m_e.mode = 2'(m_mode);
        m_e.grant = (m_mode == 0);
        sb_q.push_back(m_e);
      end
    end
  end

  // Monitor: outputs are registered, so compare them mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_led_out", led_out, e.led);
        check("sb_pb_clean", pb_clean, e.pb);
        check("sb_mode", mode, e.mode);
        check("sb_cpu_grant", cpu_grant, e.grant);
      end
    end
  end

  task automatic press(input int b, input int len);
    pb_n[b] = 1'b0;
    cyc(len);
    pb_n[b] = 1'b1;
    cyc(8);
  endtask

  // Directed scenarios followed by randomized button/CPU activity.
  initial begin
    logic [7:0] v;
    logic [7:0] e8;
    bit found;
    int hold_left [4];

    reset_n = 1'b0; pb_n = 4'hF; cpu_led = 8'h00; cpu_req = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(2);
    check("reset_pb_clean", pb_clean, 4'hF);
    check("reset_mode", mode, 2'b00);
    check("reset_grant", cpu_grant, 1'b1);

    // Short glitch on pb1 must never reach pb_clean.
    pb_n[1] = 1'b0; cyc(3); pb_n[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("glitch_pb_clean", pb_clean, 4'hF);
    end

    // Real press: clean level falls exactly 6 clocks after the raw edge.
    pb_n[1] = 1'b0;
    cyc(5); check("deb_not_yet", pb_clean, 4'hF);
    cyc(1); check("deb_edge", pb_clean, 4'hD);
    cyc(1); check("press_to_scan", mode, 2'b01);
    cyc(1); check("scan_first_led", led_out, 8'h01);

    // SCAN walks 0x02..0x80 then wraps to 0x01, one step every 3 clocks.
    for (int k = 1; k <= 8; k++) begin
      cyc(3);
      e8 = 8'h01 << (k % 8);
      check("scan_step", led_out, e8);
      if (k == 1) pb_n[1] = 1'b1;
    end

    // Asynchronous reset mid-SCAN takes effect without a clock edge.
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_led", led_out, 8'h00);
    check("async_rst_mode", mode, 2'b00);
    check("async_rst_grant", cpu_grant, 1'b1);
    check("async_rst_pb", pb_clean, 4'hF);
    @(negedge clk); cyc(1);
    reset_n = 1'b1;
    cyc(2);

    // COUNT with pause/resume and the 0xFF -> 0x00 wrap.
    press(1, 10);
    press(1, 10);
    check("count_mode", mode, 2'b10);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc(1);
      if (led_out == 8'h05) found = 1;
    end
    check("count_reach_05", found, 1'b1);
    pb_n[2] = 1'b0;
    cyc(9);
    v = led_out;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (i == 0) pb_n[2] = 1'b1;
      check("pause_hold", led_out, v);
    end
    pb_n[2] = 1'b0; cyc(10); pb_n[2] = 1'b1; cyc(1);
    check("resume_step", led_out, v + 8'h01);
    found = 0;
    for (int i = 0; i < 900 && !found; i++) begin
      cyc(1);
      if (led_out == 8'hFF) found = 1;
    end
    check("count_reach_ff", found, 1'b1);
    cyc(3);
    check("count_wrap", led_out, 8'h00);

    // HOLD freezes the count; pb3 forces the CPU back in.
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc(1);
      if (led_out == 8'h09) found = 1;
    end
    check("count_reach_09", found, 1'b1);
    pb_n[1] = 1'b0; cyc(10); pb_n[1] = 1'b1; cyc(1);
    check("hold_mode", mode, 2'b11);
    v = led_out;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("hold_frozen", led_out, v);
    end
    pb_n[3] = 1'b0;
    cyc(7); check("force_cpu", mode, 2'b00);
    cyc(3); pb_n[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e8 = 8'($urandom);
      cpu_led = e8;
      cyc(1);
      check("cpu_follow", led_out, e8);
    end
    cyc(8);

    // cpu_req wins over a simultaneous press and blocks later presses.
    press(1, 10);
    check("arb_pre_scan", mode, 2'b01);
    cpu_led = 8'hA5;
    pb_n[1] = 1'b0;
    cyc(6); cpu_req = 1'b1;
    cyc(1);
    check("arb_mode", mode, 2'b00);
    check("arb_grant", cpu_grant, 1'b1);
    cyc(1); check("arb_led", led_out, 8'hA5);
    cyc(2); pb_n[1] = 1'b1; cyc(8);
    press(1, 10);
    check("arb_ignore_press", mode, 2'b00);
    cpu_req = 1'b0;
    cyc(5);
    check("req_drop_stays_cpu", mode, 2'b00);

    // Randomized activity, checked by the scoreboard.
    for (int b = 0; b < 4; b++) hold_left[b] = 0;
    for (int c = 0; c < 2500; c++) begin
      cpu_led = 8'($urandom);
      if ($urandom_range(0, 39) == 0) cpu_req = ~cpu_req;
      for (int b = 0; b < 4; b++) begin
        if (hold_left[b] == 0) begin
          if (b == 3) pb_n[b] = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
          else pb_n[b] = 1'($urandom);
          hold_left[b] = $urandom_range(1, 12);
        end else begin
          hold_left[b]--;
        end
      end
      cyc(1);
    end

    cyc(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
